// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: request op field layout,
// access size encodings and the controller state type.
package mem_access_pkg;

  localparam int unsigned OP_STORE = 3;
  localparam int unsigned OP_UNS   = 2;
  localparam int unsigned OP_SZ_HI = 1;
  localparam int unsigned OP_SZ_LO = 0;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Reserved size or an access not naturally aligned within the word.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane steering: extracts and extends sub-word loads and
// merges sub-word store data into an existing RAM word.
module lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{~uns & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{~uns & half_sel[15]}}, half_sel};
      default: load_data = word;
    endcase

    store_word = word;
    case (size)
      SZ_BYTE: store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (offset[1]) store_word[31:16] = wdata[15:0];
        else           store_word[15:0]  = wdata[15:0];
      end
      SZ_WORD: store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the single-port data RAM: valid/ready request in,
// read-modify-write for sub-word stores, extended load data out.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rword_q, rword_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         align_word;
  logic [31:0]         load_data;
  logic [31:0]         store_word;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  // READ extracts straight from the RAM port; WRITE merges into the registered word.
  assign align_word = (state_q == ST_READ) ? mem_rdata : rword_q;

  lane_align u_lane_align (
    .word       (align_word),
    .offset     (off_q),
    .size       (op_q[OP_SZ_HI:OP_SZ_LO]),
    .uns        (op_q[OP_UNS]),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    waddr_d = waddr_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    rword_d = rword_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    mem_we     = (state_q == ST_WRITE);
    mem_addr   = waddr_q;
    mem_wdata  = (state_q == ST_WRITE) ? store_word : '0;
    resp_rdata = rdata_q;
    resp_err   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          waddr_d = req_addr[ADDR_W+1:2];
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          if (is_bad_access(req_op[OP_SZ_HI:OP_SZ_LO], req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (req_op[OP_STORE] && (req_op[OP_SZ_HI:OP_SZ_LO] == SZ_WORD)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        rword_d = mem_rdata;
        if (op_q[OP_STORE]) begin
          state_d = ST_WRITE;
        end else begin
          rdata_d = load_data;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      waddr_q <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rword_q <= rword_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
